// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: access sizes, the EX/MEM register layout
// and the lane helpers used by the data-memory path.
package mips_pkg;

  localparam logic [1:0] MEMSIZE_WORD = 2'b00;
  localparam logic [1:0] MEMSIZE_HALF = 2'b01;
  localparam logic [1:0] MEMSIZE_BYTE = 2'b10;

  typedef struct packed {
    logic        memtoReg;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  memSize;
    logic        memSigned;
    logic [31:0] aluResult;
    logic [31:0] rtData;
    logic [4:0]  rtOrRd;
  } ex_mem_t;

  // Little-endian byte enables; an illegal size enables nothing.
  function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] addrLo);
    logic [3:0] be;
    case (size)
      MEMSIZE_WORD: be = 4'b1111;
      MEMSIZE_HALF: be = addrLo[1] ? 4'b1100 : 4'b0011;
      MEMSIZE_BYTE: be = 4'b0001 << addrLo;
      default:      be = 4'b0000;
    endcase
    return be;
  endfunction

  // Sub-word store data is replicated so whichever lane is enabled sees it.
  function automatic logic [31:0] storeData(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] wd;
    case (size)
      MEMSIZE_HALF: wd = {2{data[15:0]}};
      MEMSIZE_BYTE: wd = {4{data[7:0]}};
      default:      wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/data_mem.sv
// Word-organised data memory: asynchronous read, synchronous byte-enabled write.
// Contents are deliberately not reset.
module data_mem #(
  parameter int unsigned DM_WORDS = 1024,
  parameter int unsigned DM_AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [DM_AW-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [0:DM_WORDS-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register plus data-memory access for the non-forwarding 5-stage pipeline.
// Handles stall/flush, sub-word load extension, store lane enables and misalignment.
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned DM_WORDS = 1024,
  parameter int unsigned DM_AW    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [31:0] aluResult,
  input  logic [31:0] rtData,
  input  logic [4:0]  rt_Or_rd,
  output logic        MemtoReg_out,
  output logic        RegWrite_out,
  output logic [31:0] dmReadData,
  output logic [31:0] aluResult_out,
  output logic [4:0]  rt_Or_rd_out,
  output logic        mem_misalign
);

  ex_mem_t exIn;
  ex_mem_t exMem_d, exMem_q;

  logic [1:0]       addrLo;
  logic [DM_AW-1:0] wordAddr;
  logic             memWe;
  logic [3:0]       memBe;
  logic [31:0]      memWdata;
  logic [31:0]      memRdata;
  logic [7:0]       byteLane;
  logic [15:0]      halfLane;

  assign exIn = '{
    memtoReg:  MemtoReg,
    regWrite:  RegWrite,
    memRead:   MemRead,
    memWrite:  MemWrite,
    memSize:   MemSize,
    memSigned: MemSigned,
    aluResult: aluResult,
    rtData:    rtData,
    rtOrRd:    rt_Or_rd
  };

  // Flush beats stall: a bubble still carries the incoming data fields.
  always_comb begin
    exMem_d = exMem_q;
    if (flush) begin
      exMem_d          = exIn;
      exMem_d.memtoReg = 1'b0;
      exMem_d.regWrite = 1'b0;
      exMem_d.memRead  = 1'b0;
      exMem_d.memWrite = 1'b0;
    end else if (!stall) begin
      exMem_d = exIn;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exMem_q <= '0;
    end else begin
      exMem_q <= exMem_d;
    end
  end

  assign addrLo   = exMem_q.aluResult[1:0];
  assign wordAddr = exMem_q.aluResult[DM_AW+1:2];

  always_comb begin
    mem_misalign = 1'b0;
    if (exMem_q.memRead || exMem_q.memWrite) begin
      case (exMem_q.memSize)
        MEMSIZE_WORD: mem_misalign = (addrLo != 2'b00);
        MEMSIZE_HALF: mem_misalign = addrLo[0];
        MEMSIZE_BYTE: mem_misalign = 1'b0;
        default:      mem_misalign = 1'b1;
      endcase
    end
  end

  // rst_n gates the write so a store held across a reset edge is dropped.
  assign memWe    = rst_n && exMem_q.memWrite && !mem_misalign && !stall;
  assign memBe    = byteEnable(exMem_q.memSize, addrLo);
  assign memWdata = storeData(exMem_q.memSize, exMem_q.rtData);

  data_mem #(
    .DM_WORDS (DM_WORDS),
    .DM_AW    (DM_AW)
  ) u_data_mem (
    .clk   (clk),
    .we    (memWe),
    .be    (memBe),
    .addr  (wordAddr),
    .wdata (memWdata),
    .rdata (memRdata)
  );

  assign byteLane = memRdata[8*addrLo +: 8];
  assign halfLane = addrLo[1] ? memRdata[31:16] : memRdata[15:0];

  always_comb begin
    dmReadData = '0;
    if (exMem_q.memRead && !mem_misalign) begin
      case (exMem_q.memSize)
        MEMSIZE_BYTE: dmReadData = {{24{exMem_q.memSigned & byteLane[7]}}, byteLane};
        MEMSIZE_HALF: dmReadData = {{16{exMem_q.memSigned & halfLane[15]}}, halfLane};
        default:      dmReadData = memRdata;
      endcase
    end
  end

  assign MemtoReg_out  = exMem_q.memtoReg;
  assign RegWrite_out  = exMem_q.regWrite && !mem_misalign;
  assign aluResult_out = exMem_q.aluResult;
  assign rt_Or_rd_out  = exMem_q.rtOrRd;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: each driven cycle pushes the hand-computed outputs expected
// after the next edge; a monitor pops and compares one record per cycle.
module tb_ex_mem_stage;

  localparam logic [1:0] W = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] B = 2'b10;

  typedef struct {
    bit          rstn;
    bit          stl;
    bit          fl;
    bit          m2r;
    bit          rw;
    bit          mr;
    bit          mw;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  rd;
  } stim_t;

  typedef struct {
    string       name;
    bit          m2r;
    bit          rw;
    bit          mis;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        MemtoReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemSigned;
  logic [31:0] aluResult;
  logic [31:0] rtData;
  logic [4:0]  rt_Or_rd;
  logic        MemtoReg_out;
  logic        RegWrite_out;
  logic [31:0] dmReadData;
  logic [31:0] aluResult_out;
  logic [4:0]  rt_Or_rd_out;
  logic        mem_misalign;

  exp_t expQ[$];
  int   nVec  = 0;
  int   nMiss = 0;

  ex_mem_stage #(
    .DM_WORDS (1024),
    .DM_AW    (10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .MemtoReg      (MemtoReg),
    .RegWrite      (RegWrite),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemSize       (MemSize),
    .MemSigned     (MemSigned),
    .aluResult     (aluResult),
    .rtData        (rtData),
    .rt_Or_rd      (rt_Or_rd),
    .MemtoReg_out  (MemtoReg_out),
    .RegWrite_out  (RegWrite_out),
    .dmReadData    (dmReadData),
    .aluResult_out (aluResult_out),
    .rt_Or_rd_out  (rt_Or_rd_out),
    .mem_misalign  (mem_misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t st(bit rstn, bit stl, bit fl, bit m2r, bit rw, bit mr, bit mw,
                               logic [1:0] sz, bit sg, logic [31:0] alu, logic [31:0] rt,
                               logic [4:0] rd);
    stim_t s;
    s.rstn = rstn; s.stl = stl; s.fl = fl; s.m2r = m2r; s.rw = rw; s.mr = mr; s.mw = mw;
    s.sz = sz; s.sg = sg; s.alu = alu; s.rt = rt; s.rd = rd;
    return s;
  endfunction

  function automatic exp_t ex(string name, bit m2r, bit rw, bit mis, logic [31:0] alu,
                              logic [4:0] rd, logic [31:0] rdata);
    exp_t e;
    e.name = name; e.m2r = m2r; e.rw = rw; e.mis = mis; e.alu = alu; e.rd = rd;
    e.rdata = rdata;
    return e;
  endfunction

  task automatic apply(input stim_t s, input exp_t e);
    @(negedge clk);
    rst_n     = s.rstn;
    stall     = s.stl;
    flush     = s.fl;
    MemtoReg  = s.m2r;
    RegWrite  = s.rw;
    MemRead   = s.mr;
    MemWrite  = s.mw;
    MemSize   = s.sz;
    MemSigned = s.sg;
    aluResult = s.alu;
    rtData    = s.rt;
    rt_Or_rd  = s.rd;
    expQ.push_back(e);
  endtask

  // Monitor: one record describes the outputs after one clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        nVec++;
        if (MemtoReg_out !== e.m2r || RegWrite_out !== e.rw || mem_misalign !== e.mis ||
            aluResult_out !== e.alu || rt_Or_rd_out !== e.rd || dmReadData !== e.rdata) begin
          nMiss++;
          $display("FAIL %s: got m2r=%0b rw=%0b mis=%0b alu=%h rd=%0d rdata=%h, want m2r=%0b rw=%0b mis=%0b alu=%h rd=%0d rdata=%h",
                   e.name, MemtoReg_out, RegWrite_out, mem_misalign, aluResult_out,
                   rt_Or_rd_out, dmReadData, e.m2r, e.rw, e.mis, e.alu, e.rd, e.rdata);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; MemSize = W; MemSigned = 1'b0;
    aluResult = '0; rtData = '0; rt_Or_rd = '0;

    // Reset holds everything at zero even with live controls on the inputs.
    apply(st(0,0,0,1,1,0,0,W,0,32'h55,0,3), ex("reset0",0,0,0,32'h0,0,32'h0));
    apply(st(0,0,0,1,1,0,0,W,0,32'h55,0,3), ex("reset1",0,0,0,32'h0,0,32'h0));
    apply(st(1,0,0,0,1,0,0,W,0,32'h55,0,3), ex("alu_after_reset",0,1,0,32'h55,3,32'h0));

    // Word store then load on the very next cycle.
    apply(st(1,0,0,0,0,0,1,W,0,32'h10,32'hDEADBEEF,0), ex("sw_10",0,0,0,32'h10,0,32'h0));
    apply(st(1,0,0,1,1,1,0,W,0,32'h10,0,8), ex("lw_10",1,1,0,32'h10,8,32'hDEADBEEF));

    // Sub-word store/loads.
    apply(st(1,0,0,0,0,0,1,W,0,32'h10,32'h0,0), ex("sw_zero_10",0,0,0,32'h10,0,32'h0));
    apply(st(1,0,0,0,0,0,1,B,0,32'h13,32'h180,0), ex("sb_13",0,0,0,32'h13,0,32'h0));
    apply(st(1,0,0,1,1,1,0,B,1,32'h13,0,9), ex("lb_13",1,1,0,32'h13,9,32'hFFFFFF80));
    apply(st(1,0,0,1,1,1,0,B,0,32'h13,0,9), ex("lbu_13",1,1,0,32'h13,9,32'h00000080));
    apply(st(1,0,0,1,1,1,0,W,0,32'h10,0,9), ex("lw_after_sb",1,1,0,32'h10,9,32'h80000000));

    // Misaligned accesses.
    apply(st(1,0,0,0,0,0,1,W,0,32'h12,32'h11111111,0), ex("sw_mis_12",0,0,1,32'h12,0,32'h0));
    apply(st(1,0,0,1,1,1,0,H,1,32'h11,0,5), ex("lh_mis_11",1,0,1,32'h11,5,32'h0));
    apply(st(1,0,0,1,1,1,0,W,0,32'h10,0,5), ex("lw_after_missw",1,1,0,32'h10,5,32'h80000000));
    apply(st(1,0,0,1,1,1,0,H,1,32'h12,0,5), ex("lh_12",1,1,0,32'h12,5,32'hFFFF8000));
    apply(st(1,0,0,1,1,1,0,H,0,32'h12,0,5), ex("lhu_12",1,1,0,32'h12,5,32'h00008000));
    apply(st(1,0,0,1,1,1,0,2'b11,0,32'h10,0,6), ex("size11_mis",1,0,1,32'h10,6,32'h0));

    // Store held by stall for three cycles, written once on release.
    apply(st(1,0,0,0,0,0,1,W,0,32'h20,32'hCAFEF00D,0), ex("sw_20",0,0,0,32'h20,0,32'h0));
    for (int i = 0; i < 3; i++)
      apply(st(1,1,0,1,1,1,0,W,0,32'h20,0,7), ex("stall_hold",0,0,0,32'h20,0,32'h0));
    apply(st(1,0,0,1,1,1,0,W,0,32'h20,0,7), ex("lw_20_release",1,1,0,32'h20,7,32'hCAFEF00D));

    // Flush turns a store into a bubble; flush also wins over stall.
    apply(st(1,0,1,0,0,0,1,W,0,32'h20,32'h0BADF00D,0), ex("flush_sw",0,0,0,32'h20,0,32'h0));
    apply(st(1,0,0,1,1,1,0,W,0,32'h20,0,7), ex("lw_after_flush",1,1,0,32'h20,7,32'hCAFEF00D));
    apply(st(1,0,1,0,1,0,0,W,0,32'h77,0,4), ex("flush_rw",0,0,0,32'h77,4,32'h0));
    apply(st(1,1,1,0,1,0,0,W,0,32'h78,0,4), ex("flush_stall",0,0,0,32'h78,4,32'h0));

    // Reset while a store is stalled discards it.
    apply(st(1,0,0,0,0,0,1,W,0,32'h24,32'h0,0), ex("sw_zero_24",0,0,0,32'h24,0,32'h0));
    apply(st(1,0,0,0,0,0,1,W,0,32'h24,32'h5A5A5A5A,0), ex("sw_24",0,0,0,32'h24,0,32'h0));
    apply(st(1,1,0,0,0,0,0,W,0,32'h99,0,0), ex("stall_sw_24",0,0,0,32'h24,0,32'h0));
    apply(st(0,1,0,0,0,0,0,W,0,32'h99,0,0), ex("reset_mid_stall",0,0,0,32'h0,0,32'h0));
    apply(st(1,0,0,1,1,1,0,W,0,32'h24,0,7), ex("lw_24_no_write",1,1,0,32'h24,7,32'h0));

    // Addresses wrap modulo the memory size.
    apply(st(1,0,0,0,0,0,1,W,0,32'h1008,32'h1234,0), ex("sw_wrap",0,0,0,32'h1008,0,32'h0));
    apply(st(1,0,0,1,1,1,0,W,0,32'h8,0,2), ex("lw_8_wrap",1,1,0,32'h8,2,32'h00001234));

    for (int i = 0; i < 5 && expQ.size() != 0; i++) @(posedge clk);
    #2;
    if (expQ.size() != 0) begin
      nMiss++;
      $display("FAIL drain: %0d records left, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
